// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: round-robin arbiter merging FP unit results onto one registered writeback port
module fp_wb_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int ID_W      = 3,
  parameter int FLEN      = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_UNITS-1:0]                 unit_done,
  input  logic [NUM_UNITS-1:0][ID_W-1:0]       unit_id,
  input  logic [NUM_UNITS-1:0][FLEN-1:0]       unit_rd,
  input  logic [NUM_UNITS-1:0][4:0]            unit_fflags,
  output logic [NUM_UNITS-1:0]                 unit_ack,
  output logic                                 wb_valid,
  output logic [ID_W-1:0]                      wb_id,
  output logic [FLEN-1:0]                      wb_data,
  input  logic                                 wb_ready,
  input  logic                                 fflags_clr,
  output logic [4:0]                           fflags_acc
);
  localparam int IW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;
  logic [NUM_UNITS-1:0] sel;
  logic gnt;
  logic grant;
  logic slot_free;
  logic retire;
  logic [4:0] wb_fflags;
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NUM_UNITS);
  endfunction
  assign slot_free = ~wb_valid | wb_ready;
  assign retire    = wb_valid & wb_ready;
  assign grant     = |unit_ack;
  // first pending unit at or after rr_ptr; ack only when the output slot can take it
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    sel     = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (!gnt && unit_done[wrap(int'(rr_ptr) + k)]) begin
        gnt                            = 1'b1;
        gnt_idx                        = wrap(int'(rr_ptr) + k);
        sel[wrap(int'(rr_ptr) + k)]    = 1'b1;
      end
    end
    unit_ack = (gnt && slot_free && rst) ? sel : '0;
  end
  // writeback register: load on grant, drain on acceptance, hold while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      wb_valid  <= 1'b0;
      wb_id     <= '0;
      wb_data   <= '0;
      wb_fflags <= '0;
    end else if (grant) begin
      rr_ptr    <= gnt_idx == IW'(NUM_UNITS - 1) ? '0 : gnt_idx + 1'b1;
      wb_valid  <= 1'b1;
      wb_id     <= unit_id[gnt_idx];
      wb_data   <= unit_rd[gnt_idx];
      wb_fflags <= unit_fflags[gnt_idx];
    end else if (wb_ready) begin
      wb_valid  <= 1'b0;
    end
  end
  // sticky exception flags; a clear coinciding with a retirement keeps only the retiring flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fflags_acc <= '0;
    else if (fflags_clr) fflags_acc <= retire ? wb_fflags : 5'd0;
    else if (retire) fflags_acc <= fflags_acc | wb_fflags;
  end
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb_fp_wb_arbiter: directed and randomized checks of fp_wb_arbiter against a behavioural model
module tb_fp_wb_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] unit_done = '0;
  logic [N-1:0][2:0] unit_id = '0;
  logic [N-1:0][63:0] unit_rd = '0;
  logic [N-1:0][4:0] unit_fflags = '0;
  logic [N-1:0] unit_ack;
  logic wb_valid;
  logic [2:0] wb_id;
  logic [63:0] wb_data;
  logic wb_ready = 1'b1;
  logic fflags_clr = 1'b0;
  logic [4:0] fflags_acc;
  int checks = 0;
  int errors = 0;
  bit m_valid;
  logic [2:0] m_id;
  logic [63:0] m_data;
  logic [4:0] m_ff;
  logic [4:0] m_acc;
  int m_rr;

  fp_wb_arbiter #(.NUM_UNITS(N), .ID_W(3), .FLEN(64)) dut (
    .clk(clk), .rst(rst), .unit_done(unit_done), .unit_id(unit_id), .unit_rd(unit_rd),
    .unit_fflags(unit_fflags), .unit_ack(unit_ack), .wb_valid(wb_valid), .wb_id(wb_id),
    .wb_data(wb_data), .wb_ready(wb_ready), .fflags_clr(fflags_clr), .fflags_acc(fflags_acc)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 0; m_id = '0; m_data = '0; m_ff = '0; m_acc = '0; m_rr = 0;
  endtask

  function automatic logic [N-1:0] model_ack();
    logic [N-1:0] a = '0;
    if (!rst || (m_valid && !wb_ready)) return a;
    for (int k = 0; k < N; k++) begin
      if (unit_done[(m_rr + k) % N]) begin
        a[(m_rr + k) % N] = 1'b1;
        return a;
      end
    end
    return a;
  endfunction

  task automatic model_edge(input logic [N-1:0] ea);
    bit ret = m_valid && wb_ready;
    if (fflags_clr) m_acc = ret ? m_ff : 5'd0;
    else if (ret) m_acc = m_acc | m_ff;
    if (ea != '0) begin
      for (int i = 0; i < N; i++) begin
        if (ea[i]) begin
          m_valid = 1; m_id = unit_id[i]; m_data = unit_rd[i]; m_ff = unit_fflags[i];
          m_rr = (i + 1) % N;
        end
      end
    end else if (wb_ready) m_valid = 0;
  endtask

  task automatic tick();
    logic [N-1:0] ea = model_ack();
    @(posedge clk);
    model_edge(ea);
    #1;
  endtask

  task automatic do_reset();
    unit_done = '0; wb_ready = 1'b1; fflags_clr = 1'b0;
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    unit_done = '1; rst = 1'b0; #1;
    checks++; if (unit_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", unit_ack); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", wb_valid); end
    checks++; if ({wb_id, wb_data, fflags_acc} !== '0) begin errors++; $display("FAIL reset_regs got %h/%h/%h want 0", wb_id, wb_data, fflags_acc); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    unit_id[2] = 3'd5; unit_rd[2] = 64'h3FF0000000000000; unit_fflags[2] = 5'h01;
    unit_done = 4'b0100; wb_ready = 1'b1; #1;
    checks++; if (unit_ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b want 0100", unit_ack); end
    tick(); unit_done = '0; #1;
    checks++; if (wb_valid !== 1'b1 || wb_id !== 3'd5) begin errors++; $display("FAIL single_wb got v=%b id=%0d want v=1 id=5", wb_valid, wb_id); end
    checks++; if (wb_data !== 64'h3FF0000000000000) begin errors++; $display("FAIL single_data got %h want 3ff0000000000000", wb_data); end
    tick();
    checks++; if (fflags_acc !== 5'h01) begin errors++; $display("FAIL single_acc got %h want 01", fflags_acc); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", wb_valid); end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < N; i++) begin unit_id[i] = 3'(i + 1); unit_rd[i] = 64'(i) * 64'h1111; end
    unit_done = '1; #1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (unit_ack !== 4'(1 << (c % N))) begin errors++; $display("FAIL fair_ack[%0d] got %b want %b", c, unit_ack, 4'(1 << (c % N))); end
      tick(); #1;
      checks++; if (wb_valid !== 1'b1 || wb_id !== 3'((c % N) + 1)) begin errors++; $display("FAIL fair_wb[%0d] got v=%b id=%0d want v=1 id=%0d", c, wb_valid, wb_id, (c % N) + 1); end
    end
    unit_done = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    unit_id[0] = 3'd6; unit_rd[0] = 64'hDEAD_BEEF_0000_0006;
    unit_id[1] = 3'd2; unit_rd[1] = 64'hCAFE_0000_0000_0002;
    unit_done = 4'b0001; #1;
    tick();
    unit_done = 4'b0010; wb_ready = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (unit_ack !== 4'b0000) begin errors++; $display("FAIL bp_ack[%0d] got %b want 0000", c, unit_ack); end
      checks++; if (wb_valid !== 1'b1 || wb_id !== 3'd6 || wb_data !== 64'hDEAD_BEEF_0000_0006) begin errors++; $display("FAIL bp_hold[%0d] got v=%b id=%0d d=%h want v=1 id=6 d=deadbeef00000006", c, wb_valid, wb_id, wb_data); end
      tick(); #1;
    end
    wb_ready = 1'b1; #1;
    checks++; if (unit_ack !== 4'b0010) begin errors++; $display("FAIL bp_release_ack got %b want 0010", unit_ack); end
    tick(); unit_done = '0; #1;
    checks++; if (wb_id !== 3'd2 || wb_data !== 64'hCAFE_0000_0000_0002) begin errors++; $display("FAIL bp_release_wb got id=%0d d=%h want id=2 d=cafe000000000002", wb_id, wb_data); end
    tick();
  endtask

  task automatic test_flags();
    do_reset();
    unit_fflags[0] = 5'h04; unit_fflags[1] = 5'h10; unit_fflags[2] = 5'h02;
    unit_done = 4'b0001; #1; tick();
    unit_done = 4'b0010; #1; tick();
    unit_done = 4'b0000; #1; tick();
    checks++; if (fflags_acc !== 5'h14) begin errors++; $display("FAIL flags_accum got %h want 14", fflags_acc); end
    unit_done = 4'b0100; #1; tick();
    unit_done = 4'b0000; fflags_clr = 1'b1; #1; tick();
    fflags_clr = 1'b0;
    checks++; if (fflags_acc !== 5'h02) begin errors++; $display("FAIL flags_clr_retire got %h want 02", fflags_acc); end
    fflags_clr = 1'b1; #1; tick();
    fflags_clr = 1'b0;
    checks++; if (fflags_acc !== 5'h00) begin errors++; $display("FAIL flags_clr got %h want 00", fflags_acc); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    unit_fflags[0] = 5'h08; unit_fflags[1] = 5'h01;
    unit_done = 4'b0001; #1; tick();
    unit_done = 4'b0010; #1; tick();
    unit_done = 4'b0000; wb_ready = 1'b0; #1; tick();
    checks++; if (wb_valid !== 1'b1 || fflags_acc !== 5'h08) begin errors++; $display("FAIL stall_setup got v=%b acc=%h want v=1 acc=08", wb_valid, fflags_acc); end
    unit_done = 4'b1111; #1;
    rst = 1'b0; model_reset(); #1;
    checks++; if (wb_valid !== 1'b0 || fflags_acc !== 5'h00 || unit_ack !== 4'b0000) begin errors++; $display("FAIL async_reset got v=%b acc=%h ack=%b want 0/00/0000", wb_valid, fflags_acc, unit_ack); end
    rst = 1'b1; unit_done = 4'b1010; wb_ready = 1'b1; #1;
    checks++; if (unit_ack !== 4'b0010) begin errors++; $display("FAIL post_reset_ack got %b want 0010", unit_ack); end
    tick(); unit_done = '0; tick();
  endtask

  task automatic test_random();
    int wait_cnt [N];
    do_reset();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        unit_id[i] = 3'($urandom); unit_rd[i] = {$urandom, $urandom}; unit_fflags[i] = 5'($urandom);
      end
      unit_done = 4'($urandom);
      if (c > 200 && c < 260) unit_done = 4'b1111;
      wb_ready = ($urandom_range(0, 3) != 0);
      fflags_clr = ($urandom_range(0, 15) == 0);
      #1;
      checks++; if (unit_ack !== model_ack()) begin errors++; $display("FAIL rand_ack[%0d] got %b want %b", c, unit_ack, model_ack()); end
      checks++; if (wb_valid !== m_valid || fflags_acc !== m_acc) begin errors++; $display("FAIL rand_state[%0d] got v=%b acc=%h want v=%b acc=%h", c, wb_valid, fflags_acc, m_valid, m_acc); end
      if (m_valid) begin
        checks++; if (wb_id !== m_id || wb_data !== m_data) begin errors++; $display("FAIL rand_wb[%0d] got id=%0d d=%h want id=%0d d=%h", c, wb_id, wb_data, m_id, m_data); end
      end
      if (c > 200 && c < 260) begin
        for (int i = 0; i < N; i++) wait_cnt[i] = unit_ack[i] ? 0 : (unit_ack != '0 ? wait_cnt[i] + 1 : wait_cnt[i]);
        for (int i = 0; i < N; i++) begin
          checks++; if (wait_cnt[i] >= N) begin errors++; $display("FAIL starve[%0d] unit %0d waited %0d grants want < %0d", c, i, wait_cnt[i], N); end
        end
      end
      tick();
    end
    unit_done = '0; wb_ready = 1'b1; fflags_clr = 1'b0;
    tick(); tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_flags();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
